maxpool_stream_2x2: RTL and testbench

//  Streaming 2x2 max-pool engine for the YOLOv3-tiny feature-map path. It accepts raster-order

---
 rtl/maxpool_pkg.sv | 14 +
 rtl/maxpool_lane_max4.sv | 21 ++
 rtl/maxpool_stream_2x2.sv | 179 +++++++++++++++++
 tb/tb_maxpool_stream_2x2.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared mode encodings and FSM state type for the streaming 2x2 max-pool engine.
package maxpool_pkg;

    localparam logic MP_STRIDE2 = 1'b0;
    localparam logic MP_STRIDE1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } mp_state_e;

endpackage

// File: rtl/maxpool_lane_max4.sv
// Combinational signed maximum of four lane values; 2-input use passes duplicated operands.
module maxpool_lane_max4 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    output logic signed [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] ab;
    logic signed [DATA_WIDTH-1:0] cd;

    always_comb begin
        ab = (a > b) ? a : b;
        cd = (c > d) ? c : d;
        y  = (ab > cd) ? ab : cd;
    end

endmodule

// File: rtl/maxpool_stream_2x2.sv
// Streaming 2x2 max-pool: one-row line buffer, stride 2 or stride 1 with right/bottom
// replicate padding, valid/ready on both sides and a registered output.
module maxpool_stream_2x2
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 16,
    parameter int MAX_IMG_W  = 416,
    parameter int CNT_W      = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cfg_w,
    input  logic [CNT_W-1:0]             cfg_h,
    input  logic                         cfg_stride1,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*NUM_CH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*NUM_CH-1:0] out_data,
    output logic                         busy,
    output logic                         done,
    output mp_state_e                    dbg_state
);

    localparam int PIX_W = DATA_WIDTH * NUM_CH;

    // Handshake rule: a pixel moves when in_valid && in_ready, a pooled pixel moves when
    // out_valid && out_ready; out_data holds steady while out_valid && !out_ready.
    mp_state_e        state, state_n;
    logic [CNT_W-1:0] w_q, h_q, row, col, rd_addr;
    logic             stride1_q, eol_bubble;
    logic [PIX_W-1:0] prev_top, prev_bot, fl_reg, lb_q;
    logic [PIX_W-1:0] lb_mem [MAX_IMG_W];
    logic [CNT_W:0]   col_p1, col_p2, w_last;

    logic             slot_free, accept, last_col, last_row;
    logic             bubble_issue, flush_issue, acc_emit, load;
    logic [PIX_W-1:0] op_a, op_b, op_c, op_d, max_out;

    assign slot_free    = !out_valid || out_ready;
    assign in_ready     = (state == RUN) && !eol_bubble && slot_free;
    assign accept       = in_valid && in_ready;
    assign last_col     = (col == w_q - 1'b1);
    assign last_row     = (row == h_q - 1'b1);
    assign bubble_issue = eol_bubble && slot_free;
    assign flush_issue  = (state == FLUSH) && !eol_bubble && slot_free;
    assign acc_emit     = accept && ((stride1_q == MP_STRIDE1) ? (row != '0 && col != '0)
                                                               : (stride1_q == MP_STRIDE2 && row[0] && col[0]));
    assign load         = acc_emit || bubble_issue || flush_issue;
    assign busy         = (state != IDLE);
    assign done         = (state == DRAIN) && out_valid && out_ready;
    assign dbg_state    = state;

    assign col_p1 = {1'b0, col} + (CNT_W+1)'(1);
    assign col_p2 = {1'b0, col} + (CNT_W+1)'(2);
    assign w_last = {1'b0, w_q} - (CNT_W+1)'(1);

    // The registered read is issued one column ahead so lb_q already holds the
    // upper-row pixel when the matching input arrives, keeping accept-to-output at 1 cycle.
    always_comb begin
        rd_addr = col;
        case (state)
            RUN: begin
                if (accept) rd_addr = last_col ? '0 : col + 1'b1;
            end
            FLUSH: begin
                if (eol_bubble) begin
                    if (bubble_issue) rd_addr = (col_p1 > w_last) ? w_last[CNT_W-1:0] : col_p1[CNT_W-1:0];
                end else if (flush_issue) begin
                    rd_addr = (col_p2 > w_last) ? w_last[CNT_W-1:0] : col_p2[CNT_W-1:0];
                end else begin
                    rd_addr = (col_p1 > w_last) ? w_last[CNT_W-1:0] : col_p1[CNT_W-1:0];
                end
            end
            default: rd_addr = col;
        endcase
    end

    always_comb begin
        op_a = prev_top;
        op_b = lb_q;
        op_c = prev_bot;
        op_d = in_data;
        if (flush_issue) begin
            op_a = fl_reg;
            op_b = lb_q;
            op_c = fl_reg;
            op_d = lb_q;
        end else if (bubble_issue) begin
            op_a = prev_top;
            op_b = prev_bot;
            op_c = prev_top;
            op_d = prev_bot;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        maxpool_lane_max4 #(.DATA_WIDTH(DATA_WIDTH)) u_max (
            .a (op_a[k*DATA_WIDTH +: DATA_WIDTH]),
            .b (op_b[k*DATA_WIDTH +: DATA_WIDTH]),
            .c (op_c[k*DATA_WIDTH +: DATA_WIDTH]),
            .d (op_d[k*DATA_WIDTH +: DATA_WIDTH]),
            .y (max_out[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (accept && last_col && last_row) state_n = stride1_q ? FLUSH : DRAIN;
            FLUSH:   if (flush_issue && last_col) state_n = DRAIN;
            DRAIN:   if (slot_free) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) lb_mem[col] <= in_data;
        lb_q <= lb_mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            stride1_q  <= 1'b0;
            row        <= '0;
            col        <= '0;
            eol_bubble <= 1'b0;
            prev_top   <= '0;
            prev_bot   <= '0;
            fl_reg     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                w_q        <= cfg_w;
                h_q        <= cfg_h;
                stride1_q  <= cfg_stride1;
                row        <= '0;
                col        <= '0;
                eol_bubble <= 1'b0;
            end
            if (accept) begin
                prev_top <= lb_q;
                prev_bot <= in_data;
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                    if (stride1_q && row != '0) eol_bubble <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // The end-of-row slot also primes fl_reg with lb[0] for the flush sweep.
            if (bubble_issue) begin
                eol_bubble <= 1'b0;
                fl_reg     <= lb_q;
            end
            if (flush_issue) begin
                fl_reg <= lb_q;
                col    <= col + 1'b1;
            end
            if (load) begin
                out_data  <= max_out;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream_2x2.sv
// Directed and model-checked bench for maxpool_stream_2x2 with two signed 16-bit lanes.
module tb_maxpool_stream_2x2;
    import maxpool_pkg::*;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int PW  = DW * NCH;
    localparam int CW  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_w = '0;
    logic [CW-1:0] cfg_h = '0;
    logic          cfg_stride1 = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_data;
    logic          busy;
    logic          done;
    mp_state_e     dbg_state;

    int            n_total = 0;
    int            n_bad = 0;
    int            done_cnt = 0;
    int            done_idx = 0;
    bit            ready_mode = 1'b0;
    logic [PW-1:0] frame[$];
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int            wait_q[$];

    maxpool_stream_2x2 #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_IMG_W(416), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_stride1(cfg_stride1), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = ready_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
        if (!rst && done) begin
            done_cnt++;
            done_idx = got_q.size();
        end
    end

    function automatic logic [PW-1:0] mk_pix(input int lane1, input int lane0);
        logic [DW-1:0] h, l;
        h = DW'(lane1);
        l = DW'(lane0);
        return {h, l};
    endfunction

    function automatic logic [PW-1:0] pmax(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0]        r;
        logic signed [DW-1:0] x, y;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            x = a[k*DW +: DW];
            y = b[k*DW +: DW];
            r[k*DW +: DW] = (x > y) ? x : y;
        end
        return r;
    endfunction

    // Reference pooling straight from the frame: stride-1 windows clip at the right/bottom edge.
    function automatic void build_expected(input int w, input int h, input logic s1);
        int r2, c2;
        exp_q.delete();
        if (s1) begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    r2 = (r + 1 < h) ? r + 1 : r;
                    c2 = (c + 1 < w) ? c + 1 : c;
                    exp_q.push_back(pmax(pmax(frame[r*w+c], frame[r*w+c2]),
                                         pmax(frame[r2*w+c], frame[r2*w+c2])));
                end
            end
        end else begin
            for (int i = 0; i < h / 2; i++) begin
                for (int j = 0; j < w / 2; j++) begin
                    exp_q.push_back(pmax(pmax(frame[2*i*w+2*j], frame[2*i*w+2*j+1]),
                                         pmax(frame[(2*i+1)*w+2*j], frame[(2*i+1)*w+2*j+1])));
                end
            end
        end
    endfunction

    task automatic clear_sb();
        got_q.delete();
        wait_q.delete();
        done_cnt = 0;
        done_idx = 0;
    endtask

    task automatic pulse_start(input int w, input int h, input logic s1);
        cfg_w = CW'(w);
        cfg_h = CW'(h);
        cfg_stride1 = s1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [PW-1:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && waits < 2000) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        seen = (done_cnt != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int w, input int h, input logic s1, output bit seen);
        int wt;
        pulse_start(w, h, s1);
        for (int i = 0; i < w * h; i++) begin
            send_pixel(frame[i], wt);
            wait_q.push_back(wt);
        end
        wait_done(4000, seen);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", done); end
        n_total++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_state got=%0d want=IDLE", dbg_state); end
    endtask

    task automatic load_ramp(input int n);
        frame.delete();
        for (int v = 1; v <= n; v++) frame.push_back(mk_pix(-v, v));
    endtask

    task automatic test_stride2_basic();
        logic [PW-1:0] want[2];
        bit            seen;
        want = '{32'hFFFF_0006, 32'hFFFD_0008};
        clear_sb();
        load_ramp(8);
        run_frame(4, 2, 1'b0, seen);
        n_total++; if (!seen) begin n_bad++; $display("FAIL s2_done_seen got=0 want=1"); end
        n_total++; if (got_q.size() != 2) begin n_bad++; $display("FAIL s2_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL s2_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
        n_total++; if (done_cnt != 1 || done_idx != 2) begin n_bad++; $display("FAIL s2_done_pos got=%0d/%0d want=1/2", done_cnt, done_idx); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL s2_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_signed();
        logic [PW-1:0] want[2];
        bit            seen;
        want = '{32'hFFFD_FFFB, 32'hFFEC_0002};
        clear_sb();
        frame.delete();
        for (int i = 0; i < 4; i++) frame.push_back(mk_pix(-3, -5));
        run_frame(2, 2, 1'b0, seen);
        frame.delete();
        frame.push_back(mk_pix(-32768, -5));
        frame.push_back(mk_pix(-20, 2));
        frame.push_back(mk_pix(-30, -1));
        frame.push_back(mk_pix(-40, 1));
        run_frame(2, 2, 1'b0, seen);
        n_total++; if (got_q.size() != 2) begin n_bad++; $display("FAIL signed_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL signed_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
    endtask

    task automatic test_stride1_basic();
        logic [PW-1:0] want[6];
        bit            seen;
        int            wsum;
        want = '{32'hFFFF_0005, 32'hFFFE_0006, 32'hFFFD_0006, 32'hFFFC_0005, 32'hFFFB_0006, 32'hFFFA_0006};
        clear_sb();
        load_ramp(6);
        run_frame(3, 2, 1'b1, seen);
        n_total++; if (!seen) begin n_bad++; $display("FAIL s1_done_seen got=0 want=1"); end
        n_total++; if (got_q.size() != 6) begin n_bad++; $display("FAIL s1_count got=%0d want=6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL s1_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
        wsum = 0;
        foreach (wait_q[i]) wsum += wait_q[i];
        n_total++; if (wsum != 0) begin n_bad++; $display("FAIL s1_input_stalls got=%0d want=0", wsum); end
        n_total++; if (done_idx != 6) begin n_bad++; $display("FAIL s1_done_pos got=%0d want=6", done_idx); end
    endtask

    task automatic test_stride1_bubble();
        logic [PW-1:0] want[9];
        bit            seen;
        int            wsum;
        want = '{32'hFFFF_0005, 32'hFFFE_0006, 32'hFFFD_0006, 32'hFFFC_0008, 32'hFFFB_0009,
                 32'hFFFA_0009, 32'hFFF9_0008, 32'hFFF8_0009, 32'hFFF7_0009};
        clear_sb();
        load_ramp(9);
        run_frame(3, 3, 1'b1, seen);
        n_total++; if (got_q.size() != 9) begin n_bad++; $display("FAIL bub_count got=%0d want=9", got_q.size()); end
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL bub_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
        wsum = 0;
        foreach (wait_q[i]) wsum += wait_q[i];
        n_total++; if (wait_q.size() != 9 || wait_q[6] != 1) begin n_bad++; $display("FAIL bub_px7_wait got=%0d want=1", (wait_q.size() == 9) ? wait_q[6] : -1); end
        n_total++; if (wsum != 1) begin n_bad++; $display("FAIL bub_total_stalls got=%0d want=1", wsum); end
    endtask

    task automatic test_random(input int w, input int h, input logic s1);
        bit seen;
        clear_sb();
        frame.delete();
        for (int i = 0; i < w * h; i++) frame.push_back(PW'($urandom));
        build_expected(w, h, s1);
        ready_mode = 1'b1;
        run_frame(w, h, s1, seen);
        ready_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (!seen) begin n_bad++; $display("FAIL rand_w%0d_done_seen got=0 want=1", w); end
        n_total++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_w%0d_count got=%0d want=%0d", w, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL rand_w%0d_out%0d got=%h want=%h", w, i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_total++; if (done_idx != exp_q.size()) begin n_bad++; $display("FAIL rand_w%0d_done_pos got=%0d want=%0d", w, done_idx, exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [PW-1:0] want[2];
        bit            seen;
        int            wt;
        want = '{32'hFFFF_0006, 32'hFFFD_0008};
        clear_sb();
        frame.delete();
        for (int i = 0; i < 16 * 8; i++) frame.push_back(PW'($urandom));
        pulse_start(16, 8, 1'b0);
        for (int i = 0; i < 3 * 16 + 7; i++) send_pixel(frame[i], wt);
        in_valid = 1'b1;
        in_data = frame[3 * 16 + 7];
        rst = 1'b1;
        #1;
        n_total++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL midrst_state got=%0d want=IDLE", dbg_state); end
        n_total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_flags got=%b%b%b want=000", busy, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clear_sb();
        load_ramp(8);
        run_frame(4, 2, 1'b0, seen);
        n_total++; if (got_q.size() != 2) begin n_bad++; $display("FAIL midrst_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL midrst_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [PW-1:0] want[2];
        bit            seen;
        int            wt;
        want = '{32'hFFFF_0006, 32'hFFFD_0008};
        clear_sb();
        load_ramp(8);
        pulse_start(4, 2, 1'b0);
        for (int i = 0; i < 3; i++) send_pixel(frame[i], wt);
        pulse_start(2, 2, 1'b1);
        n_total++; if (dbg_state !== RUN) begin n_bad++; $display("FAIL ign_state got=%0d want=RUN", dbg_state); end
        for (int i = 3; i < 8; i++) send_pixel(frame[i], wt);
        wait_done(200, seen);
        n_total++; if (got_q.size() != 2) begin n_bad++; $display("FAIL ign_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin
                n_bad++; $display("FAIL ign_out%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, want[i]);
            end
        end
        in_valid = 1'b1;
        in_data = mk_pix(7, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready cyc%0d got=%b want=0", i, in_ready); end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_total++; if (got_q.size() != 2 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_activity got=%0d/%b want=2/0", got_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_stride2_basic();
        test_signed();
        test_stride1_basic();
        test_stride1_bubble();
        test_random(16, 8, 1'b0);
        test_random(6, 5, 1'b1);
        test_random(416, 2, 1'b0);
        test_reset_mid_frame();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
